// File: rtl/trojan_trigger_sequencer.sv
// Activation-stimulus generator: streams the four-word trigger plaintext onto the AES state input
// over a valid/ready handshake, with an optional idle gap after each non-final word.
module trojan_trigger_sequencer #(
  parameter logic [127:0] WORD0      = 128'h3243f6a8_885a308d_313198a2_e0370734,
  parameter logic [127:0] WORD1      = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter logic [127:0] WORD2      = 128'h0,
  parameter logic [127:0] WORD3      = 128'h1,
  parameter int unsigned  GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] out_state,
  output logic         out_last,
  output logic [1:0]   seq_index,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic [127:0] data_q, data_d;
  logic         last_q, last_d;
  logic [1:0]   idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rst_meta_q, rst_sync_q;

  // Assertion is immediate; release is retimed through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  function automatic logic [127:0] word_sel(input logic [1:0] i);
    unique case (i)
      2'd0:    word_sel = WORD0;
      2'd1:    word_sel = WORD1;
      2'd2:    word_sel = WORD2;
      default: word_sel = WORD3;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
      idx_d   = 2'd0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A start landing in the done cycle is dropped.
          if (start && !done_q) begin
            state_d = StSend;
            valid_d = 1'b1;
            data_d  = WORD0;
            last_d  = 1'b0;
            idx_d   = 2'd0;
            busy_d  = 1'b1;
          end
        end
        StSend: begin
          if (valid_q && out_ready) begin
            if (idx_q == 2'd3) begin
              state_d = StIdle;
              valid_d = 1'b0;
              data_d  = '0;
              last_d  = 1'b0;
              idx_d   = 2'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              idx_d  = idx_q + 2'd1;
              data_d = word_sel(idx_q + 2'd1);
              last_d = (idx_q == 2'd2);
            end else begin
              state_d = StGap;
              cnt_d   = 8'(GAP_CYCLES - 1);
              valid_d = 1'b0;
              data_d  = '0;
              last_d  = 1'b0;
              idx_d   = idx_q + 2'd1;
            end
          end
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            state_d = StSend;
            valid_d = 1'b1;
            data_d  = word_sel(idx_q);
            last_d  = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_state = data_q;
  assign out_last  = last_q;
  assign seq_index = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trojan_trigger_sequencer.sv
// Drives two sequencers (no gap / two-cycle gap) with shared directed and random stimulus and
// compares every cycle against a transfer-level reference model.
module tb_trojan_trigger_sequencer;

  logic         clk = 1'b0;
  logic         rst, start, abort, out_ready;
  logic         ov [2];
  logic [127:0] os [2];
  logic         ol [2];
  logic [1:0]   si [2];
  logic         bz [2];
  logic         dn [2];

  int total = 0;
  int bad   = 0;

  logic [127:0] words [4];
  int           gap_of [2];

  // Reference model: sequence active, word index, remaining idle cycles, done pulse.
  bit m_active [2];
  int m_idx    [2];
  int m_gap    [2];
  bit m_done   [2];

  always #5 clk = ~clk;

  trojan_trigger_sequencer #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(ov[0]), .out_state(os[0]), .out_last(ol[0]), .seq_index(si[0]),
    .busy(bz[0]), .done(dn[0])
  );

  trojan_trigger_sequencer #(.GAP_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(ov[1]), .out_state(os[1]), .out_last(ol[1]), .seq_index(si[1]),
    .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 0; m_idx[d] = 0; m_gap[d] = 0; m_done[d] = 0;
    end
  endtask

  function automatic bit m_valid(input int d);
    return m_active[d] && (m_gap[d] == 0);
  endfunction

  task automatic model_edge();
    bit was_done, vld;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      was_done  = m_done[d];
      vld       = m_valid(d);
      m_done[d] = 0;
      if (abort) begin
        m_active[d] = 0; m_idx[d] = 0; m_gap[d] = 0;
      end else if (!m_active[d]) begin
        if (start && !was_done) begin
          m_active[d] = 1; m_idx[d] = 0; m_gap[d] = 0;
        end
      end else if (!vld) begin
        m_gap[d]--;
      end else if (out_ready) begin
        if (m_idx[d] == 3) begin
          m_active[d] = 0; m_idx[d] = 0; m_done[d] = 1;
        end else begin
          m_idx[d]++;
          m_gap[d] = gap_of[d];
        end
      end
    end
  endtask

  task automatic check_all();
    logic [127:0] exp_state;
    for (int d = 0; d < 2; d++) begin
      exp_state = m_valid(d) ? words[m_idx[d]] : 128'h0;
      chk($sformatf("d%0d out_valid", d), 128'(ov[d]), 128'(m_valid(d)));
      chk($sformatf("d%0d out_state", d), os[d], exp_state);
      chk($sformatf("d%0d out_last", d), 128'(ol[d]), 128'(m_valid(d) && m_idx[d] == 3));
      chk($sformatf("d%0d seq_index", d), 128'(si[d]), 128'(m_idx[d]));
      chk($sformatf("d%0d busy", d), 128'(bz[d]), 128'(m_active[d]));
      chk($sformatf("d%0d done", d), 128'(dn[d]), 128'(m_done[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    start = 0; abort = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int busy_cnt, done_cnt, n;
    words[0]  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    words[1]  = 128'h00112233_44556677_8899aabb_ccddeeff;
    words[2]  = 128'h0;
    words[3]  = 128'h1;
    gap_of[0] = 0;
    gap_of[1] = 2;
    rst = 0; start = 0; abort = 0; out_ready = 1;
    model_reset();
    #12;
    check_all();
    rst = 1;
    idle_cycles(3);

    // Back-to-back sequence on the no-gap instance; count busy/done cycles independently.
    start = 1;
    step();
    start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (bz[0]) busy_cnt++;
      if (dn[0]) done_cnt++;
      step();
    end
    chk("t1 busy cycles", 128'(busy_cnt), 128'd4);
    chk("t1 done pulses", 128'(done_cnt), 128'd1);
    idle_cycles(8);

    // Stall while WORD1 is presented on the no-gap instance.
    start = 1;
    step();
    start = 0;
    step();
    chk("t2 word1 shown", os[0], words[1]);
    out_ready = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t2 word1 held", os[0], words[1]);
    out_ready = 1;
    idle_cycles(14);

    // Abort on the WORD2 handshake, then restart.
    start = 1;
    step();
    start = 0;
    step();
    step();
    chk("t4 word2 shown", os[0], words[2]);
    abort = 1;
    step();
    abort = 0;
    chk("t4 aborted valid", 128'(ov[0]), 128'd0);
    idle_cycles(3);
    start = 1;
    step();
    start = 0;
    chk("t4 restart word0", os[0], words[0]);
    idle_cycles(14);

    // start held high throughout: mid-sequence and done-cycle starts must be ignored.
    start = 1;
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (dn[0]) done_cnt++;
    end
    chk("t5 one done so far", 128'(done_cnt), 128'd1);
    idle_cycles(14);

    // Randomised handshake, start and abort traffic.
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(3) == 0);
      abort     = ($urandom_range(24) == 0);
      out_ready = ($urandom_range(1) == 0);
      step();
    end
    out_ready = 1;
    idle_cycles(14);

    // Async reset while WORD3 is valid on the no-gap instance.
    start = 1;
    step();
    start = 0;
    n = 0;
    while (!ol[0] && n < 20) begin
      step();
      n++;
    end
    chk("t6 reached word3", 128'(ol[0]), 128'd1);
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all();
    idle_cycles(2);
    rst = 1;
    idle_cycles(6);
    start = 1;
    step();
    start = 0;
    idle_cycles(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
